cache_mem_arbiter: RTL and testbench

Shares the single physical-memory port between the L1 instruction cache and the L1 data cache in the mp3 cache hierarchy. It accepts line-sized read and write requests from both caches, grants one at a time, latches the winner's command into a registered memory-side request, and returns the memory response only to the granted cache. It sits between the two L1 caches and `physical_memory`, replacing the direct cache-to-memory connection.

---
 rtl/cache_arb_pkg.sv | 18 +
 rtl/cache_arb_pick.sv | 22 ++
 rtl/cache_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the I/D-cache to physical-memory arbiter.
package cache_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } arb_op_t;

endpackage

// File: rtl/cache_arb_pick.sv
// Combinational winner select between I and D requests.
// CACHE_ARB_RR_EN selects round-robin; otherwise D always wins a tie.
module cache_arb_pick (
  input  logic i_req_i,
  input  logic i_req_d,
`ifdef CACHE_ARB_RR_EN
  input  logic i_last_i,
`endif
  output logic o_grant_valid,
  output logic o_grant_d
);

  assign o_grant_valid = i_req_i | i_req_d;

`ifdef CACHE_ARB_RR_EN
  // On a tie, the side not served last wins.
  assign o_grant_d = i_req_d & (~i_req_i | i_last_i);
`else
  assign o_grant_d = i_req_d;
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one physical-memory port between the L1 I-cache and D-cache.
// Define CACHE_ARB_RR_EN for round-robin ties; default is fixed D priority.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  arb_state_t        r_state;
  arb_state_t        w_state_d;
  logic              r_pmem_read;
  logic              r_pmem_write;
  logic [ADDR_W-1:0] r_pmem_address;
  logic [LINE_W-1:0] r_pmem_wdata;

  logic              w_req_i;
  logic              w_req_d;
  logic              w_grant_valid;
  logic              w_grant_d;
  arb_op_t           w_op;
  logic [ADDR_W-1:0] w_address;
  logic [LINE_W-1:0] w_wdata;

`ifdef CACHE_ARB_RR_EN
  logic              r_last_i;
`endif

  assign w_req_i = i_read | i_write;
  assign w_req_d = d_read | d_write;

  cache_arb_pick u_pick (
    .i_req_i       (w_req_i),
    .i_req_d       (w_req_d),
`ifdef CACHE_ARB_RR_EN
    .i_last_i      (r_last_i),
`endif
    .o_grant_valid (w_grant_valid),
    .o_grant_d     (w_grant_d)
  );

  // Read+write together is treated as a write.
  always_comb begin
    w_op      = OP_READ;
    w_address = i_address;
    w_wdata   = i_wdata;
    if (w_grant_d) begin
      w_op      = d_write ? OP_WRITE : OP_READ;
      w_address = d_address;
      w_wdata   = d_wdata;
    end else begin
      w_op      = i_write ? OP_WRITE : OP_READ;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_state_d = w_grant_d ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (pmem_resp) begin
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
`ifdef CACHE_ARB_RR_EN
      r_last_i       <= 1'b1;
`endif
    end else begin
      r_state <= w_state_d;
      if (r_state == IDLE && w_grant_valid) begin
        r_pmem_read    <= (w_op == OP_READ);
        r_pmem_write   <= (w_op == OP_WRITE);
        r_pmem_address <= w_address;
        r_pmem_wdata   <= w_wdata;
`ifdef CACHE_ARB_RR_EN
        r_last_i       <= ~w_grant_d;
`endif
      end else if (r_state != IDLE && pmem_resp) begin
        r_pmem_read  <= 1'b0;
        r_pmem_write <= 1'b0;
      end
    end
  end

  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;

  // Responses are suppressed while reset is asserted so an abandoned transfer never completes.
  assign i_resp  = (r_state == BUSY_I) & pmem_resp & ~rst;
  assign d_resp  = (r_state == BUSY_D) & pmem_resp & ~rst;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter (either arbitration mode).
module tb_cache_mem_arbiter;

  localparam int AW = 16;
  localparam int LW = 256;

  logic          clk;
  logic          rst;
  logic          i_read, i_write, i_resp;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_wdata, i_rdata;
  logic          d_read, d_write, d_resp;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata, d_rdata;
  logic          pmem_read, pmem_write, pmem_resp;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata, pmem_rdata;

  int total = 0;
  int bad   = 0;

`ifdef CACHE_ARB_RR_EN
  localparam logic [3:0] EXP_D_ORDER = 4'b0101;
`else
  localparam logic [3:0] EXP_D_ORDER = 4'b1111;
`endif

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_write      (i_write),
    .i_address    (i_address),
    .i_wdata      (i_wdata),
    .i_resp       (i_resp),
    .i_rdata      (i_rdata),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_resp       (d_resp),
    .d_rdata      (d_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_read = 0; i_write = 0; i_address = '0; i_wdata = '0;
    d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
    pmem_resp = 0; pmem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    step();
    step();
    total++;
    if ({pmem_read, pmem_write} !== 2'b00) begin
      bad++; $display("FAIL reset_strobes got=%b want=00", {pmem_read, pmem_write});
    end
    total++;
    if (pmem_address !== 16'h0000) begin
      bad++; $display("FAIL reset_address got=%h want=0000", pmem_address);
    end
    total++;
    if (pmem_wdata !== '0) begin
      bad++; $display("FAIL reset_wdata got=%h want=0", pmem_wdata);
    end
    total++;
    if ({i_resp, d_resp} !== 2'b00) begin
      bad++; $display("FAIL reset_resp got=%b want=00", {i_resp, d_resp});
    end
    rst = 0;
  endtask

  task automatic test_single_read();
    logic [LW-1:0] line;
    line = {32{8'hA5}};
    do_reset();
    i_read = 1; i_address = 16'h1240;
    step();
    total++;
    if ({pmem_read, pmem_write, pmem_address} !== {2'b10, 16'h1240}) begin
      bad++; $display("FAIL single_cmd got=%b%b/%h want=10/1240", pmem_read, pmem_write,
                      pmem_address);
    end
    for (int k = 0; k < 9; k++) begin
      step();
      total++;
      if (pmem_read !== 1'b1 || pmem_address !== 16'h1240 || i_resp !== 1'b0) begin
        bad++; $display("FAIL single_hold got=%b/%h/%b want=1/1240/0", pmem_read, pmem_address,
                        i_resp);
      end
    end
    pmem_resp = 1; pmem_rdata = line;
    @(negedge clk);
    total++;
    if ({i_resp, d_resp} !== 2'b10) begin
      bad++; $display("FAIL single_resp got=%b want=10", {i_resp, d_resp});
    end
    total++;
    if (i_rdata !== line) begin
      bad++; $display("FAIL single_rdata got=%h want=%h", i_rdata, line);
    end
    step();
    pmem_resp = 0; pmem_rdata = '0; i_read = 0;
    @(negedge clk);
    total++;
    if ({i_resp, d_resp, pmem_read, pmem_write} !== 4'b0000) begin
      bad++; $display("FAIL single_after got=%b want=0000", {i_resp, d_resp, pmem_read, pmem_write});
    end
  endtask

  task automatic test_tie();
    logic [LW-1:0] wd;
    wd = {8{32'hDEADBEEF}};
    do_reset();
    i_read = 1; i_address = 16'h0100;
    d_write = 1; d_address = 16'h8000; d_wdata = wd;
    step();
    total++;
    if ({pmem_read, pmem_write, pmem_address} !== {2'b01, 16'h8000}) begin
      bad++; $display("FAIL tie_first got=%b%b/%h want=01/8000", pmem_read, pmem_write,
                      pmem_address);
    end
    total++;
    if (pmem_wdata !== wd) begin
      bad++; $display("FAIL tie_wdata got=%h want=%h", pmem_wdata, wd);
    end
    step();
    pmem_resp = 1;
    @(negedge clk);
    total++;
    if ({i_resp, d_resp} !== 2'b01) begin
      bad++; $display("FAIL tie_d_resp got=%b want=01", {i_resp, d_resp});
    end
    step();
    pmem_resp = 0; d_write = 0;
    total++;
    if ({pmem_read, pmem_write} !== 2'b00) begin
      bad++; $display("FAIL tie_gap got=%b want=00", {pmem_read, pmem_write});
    end
    step();
    total++;
    if ({pmem_read, pmem_write, pmem_address} !== {2'b10, 16'h0100}) begin
      bad++; $display("FAIL tie_second got=%b%b/%h want=10/0100", pmem_read, pmem_write,
                      pmem_address);
    end
    pmem_resp = 1;
    @(negedge clk);
    total++;
    if ({i_resp, d_resp} !== 2'b10) begin
      bad++; $display("FAIL tie_i_resp got=%b want=10", {i_resp, d_resp});
    end
    step();
    pmem_resp = 0; i_read = 0;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] exp_addr;
    logic [1:0]    exp_resp;
    do_reset();
    i_read = 1; i_address = 16'h0A00;
    d_read = 1; d_address = 16'h0D00;
    for (int k = 0; k < 4; k++) begin
      exp_addr = EXP_D_ORDER[k] ? 16'h0D00 : 16'h0A00;
      exp_resp = EXP_D_ORDER[k] ? 2'b01 : 2'b10;
      step();
      total++;
      if (pmem_read !== 1'b1 || pmem_address !== exp_addr) begin
        bad++; $display("FAIL b2b_grant%0d got=%b/%h want=1/%h", k, pmem_read, pmem_address,
                        exp_addr);
      end
      pmem_resp = 1;
      @(negedge clk);
      total++;
      if ({i_resp, d_resp} !== exp_resp) begin
        bad++; $display("FAIL b2b_resp%0d got=%b want=%b", k, {i_resp, d_resp}, exp_resp);
      end
      step();
      pmem_resp = 0;
      total++;
      if (pmem_read !== 1'b0) begin
        bad++; $display("FAIL b2b_gap%0d got=%b want=0", k, pmem_read);
      end
    end
    i_read = 0; d_read = 0;
  endtask

  task automatic test_reset_busy();
    do_reset();
    d_read = 1; d_address = 16'h3000;
    step();
    total++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h3000) begin
      bad++; $display("FAIL rstbusy_grant got=%b/%h want=1/3000", pmem_read, pmem_address);
    end
    step();
    rst = 1; d_read = 0; pmem_resp = 1;
    @(negedge clk);
    total++;
    if (d_resp !== 1'b0) begin
      bad++; $display("FAIL rstbusy_no_resp got=%b want=0", d_resp);
    end
    step();
    rst = 0; pmem_resp = 0;
    total++;
    if ({pmem_read, pmem_write} !== 2'b00) begin
      bad++; $display("FAIL rstbusy_strobes got=%b want=00", {pmem_read, pmem_write});
    end
    i_read = 1; i_address = 16'h4000;
    step();
    total++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h4000) begin
      bad++; $display("FAIL rstbusy_regrant got=%b/%h want=1/4000", pmem_read, pmem_address);
    end
    pmem_resp = 1;
    @(negedge clk);
    total++;
    if ({i_resp, d_resp} !== 2'b10) begin
      bad++; $display("FAIL rstbusy_i_resp got=%b want=10", {i_resp, d_resp});
    end
    step();
    pmem_resp = 0; i_read = 0;
  endtask

  task automatic test_drop_mid();
    do_reset();
    d_read = 1; d_address = 16'h5000;
    step();
    d_read = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (pmem_read !== 1'b1 || pmem_address !== 16'h5000) begin
        bad++; $display("FAIL drop_hold%0d got=%b/%h want=1/5000", k, pmem_read, pmem_address);
      end
    end
    pmem_resp = 1;
    @(negedge clk);
    total++;
    if (d_resp !== 1'b1) begin
      bad++; $display("FAIL drop_resp got=%b want=1", d_resp);
    end
    step();
    pmem_resp = 0;
    @(negedge clk);
    total++;
    if ({d_resp, pmem_read} !== 2'b00) begin
      bad++; $display("FAIL drop_after got=%b want=00", {d_resp, pmem_read});
    end
  endtask

  task automatic test_rw_both();
    do_reset();
    d_read = 1; d_write = 1; d_address = 16'h2000;
    step();
    total++;
    if ({pmem_read, pmem_write, pmem_address} !== {2'b01, 16'h2000}) begin
      bad++; $display("FAIL rw_both got=%b%b/%h want=01/2000", pmem_read, pmem_write,
                      pmem_address);
    end
    pmem_resp = 1;
    @(negedge clk);
    total++;
    if (d_resp !== 1'b1) begin
      bad++; $display("FAIL rw_both_resp got=%b want=1", d_resp);
    end
    step();
    pmem_resp = 0; d_read = 0; d_write = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_back_to_back();
    test_reset_busy();
    test_drop_mid();
    test_rw_both();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
